// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared types and default parameters for the serial CRC
//                engine family (state encoding, default width/poly/seed).
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    // Engine state encoding, explicit 2-bit width
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        SHIFT_OUT = 2'd2
    } crc_state_t;

    localparam int         CRC_DEF_WIDTH = 8;
    localparam logic [7:0] CRC_DEF_POLY  = 8'h44;
    localparam logic [7:0] CRC_DEF_SEED  = 8'hD8;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc_lfsr_step
//  Description : One-bit Galois LFSR step. The feedback bit (input bit XOR
//                register LSB) lands in the MSB and is XORed into every
//                lower bit whose POLY tap is set. POLY[WIDTH-1] is unused
//                because the MSB always takes the feedback.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC_DEF_POLY)
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_next
);

    logic w_fb;

    assign w_fb = i_data ^ i_state[0];

    // Lower bits shift down by one and pick up feedback where tapped
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_tap
            assign o_next[gi] = i_state[gi+1] ^ (POLY[gi] & w_fb);
        end
    endgenerate

    assign o_next[WIDTH-1] = w_fb;

endmodule : crc_lfsr_step
`default_nettype wire

// File: rtl/crc_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc_serial_engine
//  Description : Parametrised serial CRC engine. Computes a Galois CRC over
//                bits qualified by Active, then shifts the result out LSB
//                first on CRC with Valid high for exactly WIDTH cycles. The
//                seed is reloaded at every frame start.
//                Optional macro CRC_CHECK_EN adds a checker that compares
//                the CRC stream received on Data during SHIFT_OUT against
//                the computed value and reports the result on Err.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC_DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRC_DEF_SEED)
) (
    input  logic CLK,
    input  logic RST,
    input  logic Active,
    input  logic Data,
    output logic Valid,
    output logic CRC,
    output logic Busy
`ifdef CRC_CHECK_EN
    ,
    output logic Err
`endif
);

    localparam int                c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    crc_state_t         r_state;
    crc_state_t         w_state_next;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   w_lfsr_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [WIDTH-1:0]   w_step_src;
    logic [WIDTH-1:0]   w_step;

    // The first bit of a frame steps from SEED, so no reset is needed between frames
    assign w_step_src = (r_state == IDLE) ? SEED : r_lfsr;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .i_state (w_step_src),
        .i_data  (Data),
        .o_next  (w_step)
    );

    // State, CRC register and shift-out counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_lfsr  <= SEED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic and outputs decoded straight from registered state
    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_cnt_next   = r_cnt;
        Valid        = 1'b0;
        CRC          = 1'b0;
        Busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (Active) begin
                    w_lfsr_next  = w_step;
                    w_state_next = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                Busy = 1'b1;
                if (Active) begin
                    w_lfsr_next = w_step;
                end else begin
                    w_cnt_next   = '0;
                    w_state_next = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                Busy        = 1'b1;
                Valid       = 1'b1;
                CRC         = r_lfsr[0];
                w_lfsr_next = r_lfsr >> 1;
                // Counter saturates at the last bit instead of wrapping
                if (r_cnt == c_cnt_last) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef CRC_CHECK_EN
    logic r_mis;
    logic r_err;
    logic w_bit_mis;

    assign w_bit_mis = Data ^ r_lfsr[0];

    // Accumulate per-bit mismatches during shift-out; publish on the exit edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mis <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == IDLE && Active) begin
            r_mis <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == SHIFT_OUT) begin
            r_mis <= r_mis | w_bit_mis;
            if (r_cnt == c_cnt_last) begin
                r_err <= r_mis | w_bit_mis;
            end
        end
    end

    assign Err = r_err;
`endif

endmodule : crc_serial_engine
`default_nettype wire

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised serial CRC engine that generalises the team's 8-bit serial CRC block. Width, polynomial and seed are configurable. The seed reloads automatically at every frame start, so back-to-back frames need no reset. An optional checker mode compares an incoming CRC stream against the computed value. It sits between the serial framer and the line driver, where it computes the CRC over bits shifted in while `Active` is high, then shifts the CRC out LSB first.

## Interface
- `WIDTH`, 8, CRC register width (2..32).
- `POLY`, 8'h44, Galois tap mask; bit i set means feedback XORs into bit i; bit WIDTH-1 is ignored because it always takes feedback.
- `SEED`, 8'hD8, register value loaded at reset and at each frame start.

- `CLK`, in, 1, the single clock; all logic is on the rising edge.
- `RST`, in, 1, synchronous, active-high reset.
- `Active`, in, 1, frame-data qualifier; `Data` is consumed on every edge where `Active`=1 in IDLE or SHIFT_IN.
- `Data`, in, 1, serial message bit; carries the received CRC bits during SHIFT_OUT when CRC_CHECK_EN is defined.
- `Valid`, out, 1, high exactly while `CRC` carries a CRC bit.
- `CRC`, out, 1, serial CRC bit, LSB first; 0 when `Valid`=0.
- `Busy`, out, 1, high in SHIFT_IN or SHIFT_OUT.
- `Err`, out, 1, checker result; this port exists only when CRC_CHECK_EN is defined.

## Operation
- Step function step(r,d):
  - fb = d ^ r[0]
  - n[WIDTH-1] = fb
  - n[i] = r[i+1] ^ (POLY[i] & fb) for i < WIDTH-1
- States are IDLE, SHIFT_IN and SHIFT_OUT.
- IDLE:
  - With `Active`=1: load lfsr <= step(SEED, Data) and go to SHIFT_IN.
  - With `Active`=0: hold.
- SHIFT_IN:
  - With `Active`=1: lfsr <= step(lfsr, Data).
  - With `Active`=0: `Data` is not consumed, cnt <= 0, go to SHIFT_OUT.
- SHIFT_OUT:
  - `CRC` = lfsr[0]; `Valid` = 1.
  - Each edge does lfsr <= lfsr >> 1 (zero fill) and cnt++.
  - The edge at cnt == WIDTH-1 goes to IDLE.
  - `Active` is ignored throughout SHIFT_OUT.
- cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- The message length is unbounded; there is no length counter.

## Timing
- Reset values:
  - state IDLE
  - lfsr = SEED
  - cnt = 0
  - `Valid`=0, `CRC`=0, `Busy`=0, `Err`=0
- `RST` has priority over every other input, including a reset in the middle of a frame. The next edge with `Active`=1 after reset starts a clean frame.
- `Valid`, `CRC` and `Busy` decode directly from registered state with no extra pipeline stage.
- Latency: `Valid` rises in the cycle after the first edge that samples `Active`=0 in SHIFT_IN.
- `Valid` stays high for exactly WIDTH cycles, then drops.
- Back-to-back frames: `Active`=1 on the edge that leaves SHIFT_OUT is not consumed. The next frame starts on the first IDLE edge with `Active`=1, which gives a minimum gap of one IDLE cycle between frames.
- A one-bit frame is legal: `Active` high for a single edge.

## Configuration
- Macro `CRC_CHECK_EN`.
- Defined:
  - The `Err` port exists.
  - During SHIFT_OUT, an internal mismatch flag accumulates (`Data` != lfsr[0]) on each edge; it clears on entry to SHIFT_IN.
  - `Err` is registered on the edge leaving SHIFT_OUT.
  - `Err` holds until the next frame start, where it clears, or until reset.
- Undefined:
  - No `Err` port and no checker logic.
  - `Data` is ignored in SHIFT_OUT.

## Structure
- Package `crc_pkg`:
  - state enum typedef crc_state_t (IDLE, SHIFT_IN, SHIFT_OUT)
  - defaults CRC_DEF_WIDTH=8, CRC_DEF_POLY=8'h44, CRC_DEF_SEED=8'hD8
- One sub-module, `crc_lfsr_step`: the combinational step(r,d), parametrised by WIDTH and POLY, so it is reusable by a future parallel engine.

## Test plan
- Defaults, one-bit frame `Data`=0 -> lfsr 0x6C; `CRC` stream 0,0,1,1,0,1,1,0; `Valid` high for exactly 8 cycles.
- SEED=0, one-bit frame `Data`=1 -> lfsr 0xC4; `CRC` stream 0,0,1,0,0,0,1,1.
- Two frames back-to-back with a one-cycle IDLE gap -> second CRC is independent of the first, proving seed reload; `Active` held high through SHIFT_OUT is ignored.
- `RST` asserted mid-SHIFT_IN and again mid-SHIFT_OUT -> next cycle `Valid`=0, `Busy`=0, `CRC`=0; the following frame result matches a golden model.
- CRC_CHECK_EN defined, correct CRC fed on `Data` during SHIFT_OUT -> `Err`=0. Flip one bit -> `Err`=1, held until the next frame start.
- WIDTH=16, POLY=16'h1021 (bit-reversed handling via model), random 64-bit frames -> output matches the golden reference model, and `Valid` high for exactly 16 cycles.
